// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared types and constants for the next-PC sequencer.
//               Holds the sequencer state encoding, the fetch stride
//               and the default reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Architectural register width shared with the PC register.
    typedef logic [31:0] reg_size;

    // Byte stride between sequential instructions.
    localparam int INSTR_BYTES = 4;

    // Fetch address used after reset unless the instance overrides it.
    localparam reg_size RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pcseq_state_t;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_redirect_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_mux
// Description : Combinational priority select between a trap entry and
//               an EX-stage branch/jump redirect. Trap wins. The chosen
//               address is word aligned by clearing bits [1:0].
// Ports       : i_trap_req/i_trap_vec   - trap request and handler address
//               i_br_taken/i_br_target  - branch request and target
//               o_valid                 - any redirect requested
//               o_addr                  - selected, aligned address
//               o_is_trap               - selected request is the trap
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_mux #(
    parameter int XLEN = 32
) (
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    output logic            o_valid,
    output logic [XLEN-1:0] o_addr,
    output logic            o_is_trap
);

    always_comb begin
        o_valid   = i_trap_req | i_br_taken;
        o_is_trap = i_trap_req;
        o_addr    = i_trap_req ? i_trap_vec : i_br_target;
        o_addr[1:0] = 2'b00;
    end

endmodule : pc_redirect_mux
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller feeding the PC register. Chooses between
//               sequential fetch, branch/jump redirects and trap entry,
//               parks a redirect while instruction memory is busy, and
//               raises the IF/ID and ID/EX flushes. Counts applied
//               redirects.
// Ports       : clk, rst (sync, active low)
//               pc_cur        - current PC from the PC register
//               hazard_stall  - hazard unit stall request
//               imem_ready    - instruction memory accepts a fetch
//               br_taken/br_target - EX-stage redirect
//               trap_req/trap_vec  - trap entry
//               pc_next/pc_stall   - PC register PC_in / Stall
//               flush_if_id/flush_id_ex - pipeline register invalidates
//               redirect_cnt  - wrapping count of applied redirects
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                XLEN         = $bits(reg_size),
    parameter logic [XLEN-1:0]   RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int                CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_cur,
    input  logic             hazard_stall,
    input  logic             imem_ready,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_vec,
    output logic [XLEN-1:0]  pc_next,
    output logic             pc_stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] redirect_cnt
);

    pcseq_state_t      r_state;
    logic [XLEN-1:0]   r_pend_addr;
    logic              r_pend_is_trap;
    logic [CNT_W-1:0]  r_redirect_cnt;

    logic              w_br_gated;
    logic              w_sel_valid;
    logic [XLEN-1:0]   w_sel_addr;
    logic              w_sel_is_trap;
    logic              w_apply;

    // Branches only matter in RUN; in HOLD the mux then reduces to the
    // same-cycle trap override.
    assign w_br_gated = br_taken & (r_state == RUN);

    pc_redirect_mux #(
        .XLEN (XLEN)
    ) u_redirect_mux (
        .i_trap_req  (trap_req),
        .i_trap_vec  (trap_vec),
        .i_br_taken  (w_br_gated),
        .i_br_target (br_target),
        .o_valid     (w_sel_valid),
        .o_addr      (w_sel_addr),
        .o_is_trap   (w_sel_is_trap)
    );

    // Output decode. Defaults are the in-reset values.
    always_comb begin
        pc_next     = RESET_VECTOR;
        pc_stall    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        w_apply     = 1'b0;
        if (rst) begin
            case (r_state)
                BOOT: begin
                    pc_stall = 1'b0;
                end
                RUN: begin
                    if (w_sel_valid) begin
                        // Redirect overrides hazard_stall; without memory
                        // ready it is parked and the PC holds.
                        if (imem_ready) begin
                            pc_next  = w_sel_addr;
                            pc_stall = 1'b0;
                            w_apply  = 1'b1;
                        end
                    end else begin
                        pc_next     = pc_cur + XLEN'(INSTR_BYTES);
                        pc_stall    = hazard_stall | ~imem_ready;
                        flush_if_id = 1'b0;
                        flush_id_ex = 1'b0;
                    end
                end
                HOLD: begin
                    if (imem_ready) begin
                        pc_next  = w_sel_valid ? w_sel_addr : r_pend_addr;
                        pc_stall = 1'b0;
                        w_apply  = 1'b1;
                    end
                end
                default: begin
                    pc_next = RESET_VECTOR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= BOOT;
            r_pend_addr    <= '0;
            r_pend_is_trap <= 1'b0;
            r_redirect_cnt <= '0;
        end else begin
            if (w_apply) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_sel_valid && !imem_ready) begin
                        r_pend_addr    <= w_sel_addr;
                        r_pend_is_trap <= w_sel_is_trap;
                        r_state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (imem_ready) begin
                        r_state <= RUN;
                    end else if (w_sel_valid) begin
                        // Only a trap reaches here; the newer trap replaces
                        // the parked entry and the entry stays a trap.
                        r_pend_addr    <= w_sel_addr;
                        r_pend_is_trap <= r_pend_is_trap | w_sel_is_trap;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign redirect_cnt = r_redirect_cnt;

endmodule : pc_sequencer
`default_nettype wire
